// File: rtl/dsp48a1_trace_capture_if.sv
// dsp48a1_trace_capture_if: byte stream carrying 35-byte trace records
// TDATA/TVALID/TLAST driven by master, TREADY driven by slave
interface dsp48a1_trace_capture_if;
  logic [7:0] TDATA;
  logic TVALID;
  logic TREADY;
  logic TLAST;
  modport master(output TDATA, TVALID, TLAST, input TREADY);
  modport slave(input TDATA, TVALID, TLAST, output TREADY);
endinterface

// File: rtl/dsp48a1_trace_capture.sv
// dsp48a1_trace_capture: samples DSP48A1 probes into a record FIFO and serializes records MSB-first
// CLK/RST: clock and sync active-high reset; CAP_EN: capture probes this edge
// A..P: DSP48A1 probe inputs; tr: byte stream (master); FIFO_CNT: queued records
// DROP_CNT: saturating count of overflowed records; BUSY: sending or FIFO non-empty
module dsp48a1_trace_capture #(
  parameter int WIDTH_1 = 8,
  parameter int WIDTH_2 = 18,
  parameter int WIDTH_3 = 36,
  parameter int WIDTH_4 = 48,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       CAP_EN,
  input  logic [WIDTH_2-1:0]         A,
  input  logic [WIDTH_2-1:0]         B,
  input  logic [WIDTH_4-1:0]         C,
  input  logic [WIDTH_2-1:0]         D,
  input  logic [WIDTH_2-1:0]         BCIN,
  input  logic [WIDTH_1-1:0]         OPMODE,
  input  logic [WIDTH_4-1:0]         PCIN,
  input  logic                       CARRYIN,
  input  logic [WIDTH_2-1:0]         BCOUT,
  input  logic [WIDTH_3-1:0]         M,
  input  logic                       CARRYOUT,
  input  logic [WIDTH_4-1:0]         P,
  dsp48a1_trace_capture_if.master    tr,
  output logic [$clog2(DEPTH):0]     FIFO_CNT,
  output logic [CNT_W-1:0]           DROP_CNT,
  output logic                       BUSY
);
  localparam int RW = 5*WIDTH_2 + 3*WIDTH_4 + WIDTH_1 + WIDTH_3 + 2;
  localparam int NB = RW/8;
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(NB);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] shift;
  logic [RW-1:0] rec;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] idx;
  logic last, advance, pop, push, drop;
  assign rec = {A, B, C, D, BCIN, OPMODE, PCIN, CARRYIN, BCOUT, M, CARRYOUT, P};
  assign tr.TVALID = state == SEND;
  assign tr.TLAST = state == SEND && last;
  assign tr.TDATA = shift[RW-1 -: 8];
  assign BUSY = state == SEND || FIFO_CNT != 0;
  // advance: the serializer is ready for a new record (idle, or final byte accepted)
  always_comb begin
    last = idx == IW'(NB-1);
    advance = state == IDLE || (tr.TREADY && last);
    pop = advance && FIFO_CNT != 0;
    state_nx = advance ? (pop ? SEND : IDLE) : state;
    push = CAP_EN && (FIFO_CNT < (AW+1)'(DEPTH) || pop);
    drop = CAP_EN && !push;
  end
  always_ff @(posedge CLK) begin
    state <= RST ? IDLE : state_nx;
  end
  // when full, push and pop hit the same slot; the pop reads the old contents
  always_ff @(posedge CLK) begin
    if (push && !RST) mem[wr_ptr] <= rec;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      FIFO_CNT <= '0;
      DROP_CNT <= '0;
      idx <= '0;
      shift <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        shift <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
        idx <= '0;
      end else if (state == SEND && tr.TREADY && !last) begin
        shift <= shift << 8;
        idx <= idx + 1'b1;
      end
      FIFO_CNT <= FIFO_CNT + {AW'(0), push} - {AW'(0), pop};
      if (drop && !(&DROP_CNT)) DROP_CNT <= DROP_CNT + 1'b1;
    end
  end
endmodule
